// File: rtl/hnf_txreq_queue.sv
// HNF TXREQ upstream feeder: request FIFO, L-credit tracking, registered TXREQ flit
// outputs with PEND ahead of FLITV, and L-credit return on link deactivation.
package hnf_txreq_pkg;

  typedef struct packed {
    logic [3:0]  qos;
    logic [10:0] tgt_id;
    logic [10:0] src_id;
    logic [11:0] txn_id;
    logic [6:0]  opcode;
    logic [2:0]  size;
    logic [47:0] addr;
  } reqflit_t;

  localparam logic [6:0] OPC_REQLCRDRETURN = 7'h00;
  localparam logic [6:0] OPC_READNOSNP     = 7'h04;
  localparam logic [6:0] OPC_WRITENOSNP    = 7'h1C;

endpackage

module hnf_txreq_queue
  import hnf_txreq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_CRD = 15,
  parameter int unsigned CRDW    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  reqflit_t                   req_flit,
  input  logic                       link_active,
  output reqflit_t                   TXREQFLIT,
  output logic                       TXREQFLITV,
  output logic                       TXREQFLITPEND,
  input  logic                       TXREQLCRDV,
  output logic [1:0]                 link_state,
  output logic [CRDW-1:0]            crd_cnt,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       lcrd_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RETURN = 2'd2
  } link_state_e;

  link_state_e     state_q, state_d;
  reqflit_t        mem_q [DEPTH];
  reqflit_t        mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CRDW-1:0] crd_q, crd_d;
  logic            pend_q, pend_d;
  logic            flitv_q, flitv_d;
  reqflit_t        flit_q, flit_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;

  logic enq, issue_run, issue_ret, issue_any, crd_acc;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    crd_d    = crd_q;
    flit_d   = flit_q;
    flitv_d  = 1'b0;
    err_d    = err_q;

    enq       = req_valid && ready_q;
    issue_run = (state_q == ST_RUN) && pend_q && (count_q != '0) && (crd_q != '0);
    issue_ret = (state_q == ST_RETURN) && pend_q && (crd_q != '0);
    issue_any = issue_run || issue_ret;
    crd_acc   = TXREQLCRDV && (state_q != ST_STOP) && (crd_q != CRDW'(MAX_CRD));

    unique case (state_q)
      ST_STOP:   if (link_active) state_d = ST_RUN;
      ST_RUN:    if (!link_active) state_d = ST_RETURN;
      ST_RETURN: begin
        if (link_active)                         state_d = ST_RUN;
        else if ((crd_q == '0) && !TXREQLCRDV)   state_d = ST_STOP;
      end
      default:   state_d = ST_STOP;
    endcase

    if (enq) begin
      mem_d[wr_ptr_q] = req_flit;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (issue_run) begin
      flit_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else if (issue_ret) begin
      flit_d = '0;
    end
    flitv_d = issue_any;

    unique case ({enq, issue_run})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case ({crd_acc, issue_any})
      2'b10:   crd_d = crd_q + CRDW'(1);
      2'b01:   crd_d = crd_q - CRDW'(1);
      default: crd_d = crd_q;
    endcase

    // A credit at the ceiling or while stopped is a protocol violation
    if (TXREQLCRDV && ((state_q == ST_STOP) || (crd_q == CRDW'(MAX_CRD)))) err_d = 1'b1;

    pend_d  = ((state_d == ST_RUN) && (count_d != '0)) ||
              ((state_d == ST_RETURN) && (crd_d != '0));
    ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_STOP;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      crd_q    <= '0;
      pend_q   <= 1'b0;
      flitv_q  <= 1'b0;
      flit_q   <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      crd_q    <= crd_d;
      pend_q   <= pend_d;
      flitv_q  <= flitv_d;
      flit_q   <= flit_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign req_ready     = ready_q;
  assign TXREQFLIT     = flit_q;
  assign TXREQFLITV    = flitv_q;
  assign TXREQFLITPEND = pend_q;
  assign link_state    = state_q;
  assign crd_cnt       = crd_q;
  assign q_count       = count_q;
  assign lcrd_err      = err_q;

endmodule

// File: tb/tb_hnf_txreq_queue.sv
// Bench for hnf_txreq_queue: directed scenarios plus random traffic, compared each
// cycle against a queue-based reference model of the link behaviour.
module tb_hnf_txreq_queue;
  import hnf_txreq_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_CRD = 15;
  localparam int unsigned CRDW    = 4;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  reqflit_t        req_flit;
  logic            link_active;
  reqflit_t        TXREQFLIT;
  logic            TXREQFLITV;
  logic            TXREQFLITPEND;
  logic            TXREQLCRDV;
  logic [1:0]      link_state;
  logic [CRDW-1:0] crd_cnt;
  logic [CW-1:0]   q_count;
  logic            lcrd_err;

  hnf_txreq_queue #(.DEPTH(DEPTH), .MAX_CRD(MAX_CRD), .CRDW(CRDW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
    .link_active(link_active),
    .TXREQFLIT(TXREQFLIT), .TXREQFLITV(TXREQFLITV), .TXREQFLITPEND(TXREQFLITPEND),
    .TXREQLCRDV(TXREQLCRDV),
    .link_state(link_state), .crd_cnt(crd_cnt), .q_count(q_count), .lcrd_err(lcrd_err)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: link state 0 STOP / 1 RUN / 2 RETURN
  reqflit_t m_q[$];
  int       m_crd;
  int       m_st;
  bit       m_pend, m_v, m_err, m_rdy;
  reqflit_t m_flit;
  logic     prev_pend = 1'b0;
  int       n_v;
  int       n_ret;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic reqflit_t rand_flit();
    reqflit_t f;
    f.qos    = 4'($urandom());
    f.tgt_id = 11'($urandom());
    f.src_id = 11'($urandom());
    f.txn_id = 12'($urandom());
    f.opcode = ($urandom_range(0, 1) == 0) ? OPC_READNOSNP : OPC_WRITENOSNP;
    f.size   = 3'($urandom());
    f.addr   = 48'({$urandom(), $urandom()});
    return f;
  endfunction

  function automatic void model_step();
    bit       go;
    int       st_n;
    int       crd_n;
    if (reset) begin
      m_q.delete();
      m_crd = 0; m_st = 0; m_pend = 0; m_v = 0; m_err = 0; m_rdy = 0;
      m_flit = '0;
      return;
    end
    go = ((m_st == 1) && m_pend && (m_q.size() > 0) && (m_crd > 0)) ||
         ((m_st == 2) && m_pend && (m_crd > 0));
    crd_n = m_crd;
    if (TXREQLCRDV) begin
      if (m_st == 0)               m_err = 1;
      else if (m_crd == MAX_CRD)   m_err = 1;
      else                         crd_n++;
    end
    if (go) crd_n--;
    case (m_st)
      0:       st_n = link_active ? 1 : 0;
      1:       st_n = link_active ? 1 : 2;
      default: st_n = link_active ? 1 : ((m_crd == 0 && !TXREQLCRDV) ? 0 : 2);
    endcase
    if (go) m_flit = (m_st == 1) ? m_q.pop_front() : reqflit_t'('0);
    if (req_valid && m_rdy) m_q.push_back(req_flit);
    m_v    = go;
    m_st   = st_n;
    m_crd  = crd_n;
    m_pend = ((m_st == 1) && (m_q.size() > 0)) || ((m_st == 2) && (m_crd > 0));
    m_rdy  = (m_q.size() != DEPTH);
  endfunction

  task automatic check_outputs();
    chk("req_ready",  128'(req_ready),     128'(m_rdy));
    chk("flitv",      128'(TXREQFLITV),    128'(m_v));
    chk("flitpend",   128'(TXREQFLITPEND), 128'(m_pend));
    chk("flit",       128'(TXREQFLIT),     128'(m_flit));
    chk("link_state", 128'(link_state),    128'(m_st));
    chk("crd_cnt",    128'(crd_cnt),       128'(m_crd));
    chk("q_count",    128'(q_count),       128'(m_q.size()));
    chk("lcrd_err",   128'(lcrd_err),      128'(m_err));
    chk("v_after_pend", 128'(TXREQFLITV && !prev_pend), 128'(0));
    prev_pend = TXREQFLITPEND;
    if (TXREQFLITV) n_v++;
    if (TXREQFLITV && TXREQFLIT.opcode == OPC_REQLCRDRETURN) n_ret++;
  endtask

  task automatic cyc(input logic rst, input logic v, input logic la, input logic lc);
    reset       = rst;
    req_valid   = v;
    req_flit    = rand_flit();
    link_active = la;
    TXREQLCRDV  = lc;
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_flit = '0; link_active = 1'b0; TXREQLCRDV = 1'b0;

    // Reset state and ready one cycle after release
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_q",     128'(q_count),   128'(0));
    cyc(0, 0, 1, 0);
    chk("ready_after_rst", 128'(req_ready), 128'(1));
    chk("run_state", 128'(link_state), 128'(1));

    // Two flits queued without credits: pending but not valid
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    chk("s1_pend", 128'(TXREQFLITPEND), 128'(1));
    chk("s1_q",    128'(q_count),       128'(2));
    chk("s1_crd",  128'(crd_cnt),       128'(0));

    // Three credits: both flits issue back to back, one credit left
    n_v = 0;
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 1); cyc(0, 0, 1, 1);
    repeat (4) cyc(0, 0, 1, 0);
    chk("s2_issued", 128'(n_v),           128'(2));
    chk("s2_crd",    128'(crd_cnt),       128'(1));
    chk("s2_q",      128'(q_count),       128'(0));
    chk("s2_pend",   128'(TXREQFLITPEND), 128'(0));

    // Fill the FIFO, keep offering while full, then free one slot
    repeat (8) cyc(0, 1, 1, 0);
    chk("full_q",     128'(q_count),   128'(DEPTH));
    chk("full_ready", 128'(req_ready), 128'(0));
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    chk("free_ready", 128'(req_ready), 128'(1));
    chk("free_q",     128'(q_count),   128'(DEPTH - 1));

    // Issue with simultaneous credit keeps the count
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 1);
    chk("same_cyc_crd", 128'(crd_cnt), 128'(1));

    // Saturation at the credit ceiling
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (MAX_CRD) cyc(0, 0, 1, 1);
    chk("sat_crd15", 128'(crd_cnt),  128'(MAX_CRD));
    chk("sat_err0",  128'(lcrd_err), 128'(0));
    cyc(0, 0, 1, 1);
    chk("sat_crd16", 128'(crd_cnt),  128'(MAX_CRD));
    chk("sat_err1",  128'(lcrd_err), 128'(1));

    // Deactivation returns held credits, queued flit survives
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    n_ret = 0;
    cyc(0, 1, 0, 0);
    repeat (8) cyc(0, 0, 0, 0);
    chk("ret_flits", 128'(n_ret),      128'(3));
    chk("ret_stop",  128'(link_state), 128'(0));
    chk("ret_q",     128'(q_count),    128'(1));
    chk("ret_crd",   128'(crd_cnt),    128'(0));
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    repeat (5) cyc(0, 0, 1, 0);
    chk("rerun_q", 128'(q_count), 128'(0));

    // Reset in the middle of traffic
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 1); cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 0);
    chk("midrst_q",     128'(q_count),    128'(0));
    chk("midrst_crd",   128'(crd_cnt),    128'(0));
    chk("midrst_v",     128'(TXREQFLITV), 128'(0));
    chk("midrst_flit",  128'(TXREQFLIT),  128'(0));
    chk("midrst_state", 128'(link_state), 128'(0));

    // Random traffic
    begin
      logic la;
      la = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 29) == 0) la = ~la;
        cyc(logic'($urandom_range(0, 399) == 0),
            logic'($urandom_range(0, 1)),
            la,
            logic'($urandom_range(0, 99) < 35));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
